// File: rtl/hello_scroll_ctrl.sv
// rtl/hello_scroll_ctrl.sv - HELLO display scroll controller (auto/manual step, blank).
// Optional wrap gap: define HELLO_WRAP_GAP_EN to insert a blank interval on SCROLL wraps.
module hello_scroll_ctrl #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic       DIR,
    input  logic       BLANK,
    input  logic       STEP_N,
    output logic [2:0] SEL,
    output logic       TICK
);

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_SCROLL  = 2'd1,
        ST_BLANKED = 2'd2
`ifdef HELLO_WRAP_GAP_EN
        , ST_GAP   = 2'd3
`endif
    } state_t;

    localparam logic [25:0] TERM_CNT = 26'(TICK_DIV - 1);
    localparam logic [2:0]  SEL_BLANK = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  sel_q, sel_d;
    logic        tick_q, tick_d;
    logic [25:0] cnt_q, cnt_d;
    logic [1:0]  run_q, run_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  blank_q, blank_d;
    logic [2:0]  step_q, step_d;

    logic   run_s, dir_s, blank_s, step_fall, stepped;
    state_t lvl_state;

    function automatic logic [2:0] next_pos(input logic [2:0] p, input logic back);
        if (back) return (p == 3'd0) ? 3'd4 : p - 3'd1;
        else      return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    assign run_s     = run_q[1];
    assign dir_s     = dir_q[1];
    assign blank_s   = blank_q[1];
    // step_q[2] is the history flop behind the two synchronizer stages
    assign step_fall = step_q[2] & ~step_q[1];

    always_comb begin
        run_d     = {run_q[0], RUN};
        dir_d     = {dir_q[0], DIR};
        blank_d   = {blank_q[0], BLANK};
        step_d    = {step_q[1:0], STEP_N};
        lvl_state = blank_s ? ST_BLANKED : (run_s ? ST_SCROLL : ST_STOP);
        state_d   = lvl_state;
        pos_d     = pos_q;
        cnt_d     = '0;
        stepped   = 1'b0;

        case (state_q)
            ST_SCROLL: begin
                if (cnt_q == TERM_CNT) begin
                    stepped = 1'b1;
                    pos_d   = next_pos(pos_q, dir_s);
`ifdef HELLO_WRAP_GAP_EN
                    // A wrap while staying in SCROLL is deferred through GAP
                    if (lvl_state == ST_SCROLL &&
                        ((!dir_s && pos_q == 3'd4) || (dir_s && pos_q == 3'd0))) begin
                        stepped = 1'b0;
                        pos_d   = pos_q;
                        state_d = ST_GAP;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
`ifdef HELLO_WRAP_GAP_EN
            ST_GAP: begin
                if (lvl_state == ST_SCROLL) begin
                    if (cnt_q == TERM_CNT) begin
                        stepped = 1'b1;
                        pos_d   = (pos_q == 3'd4) ? 3'd0 : 3'd4;
                    end else begin
                        cnt_d   = cnt_q + 26'd1;
                        state_d = ST_GAP;
                    end
                end else begin
                    pos_d = (pos_q == 3'd4) ? 3'd0 : 3'd4;
                end
            end
`endif
            ST_STOP: begin
                if (step_fall) begin
                    stepped = 1'b1;
                    pos_d   = next_pos(pos_q, dir_s);
                end
            end
            default: ;
        endcase

        tick_d = stepped && (state_d == ST_STOP || state_d == ST_SCROLL);
        sel_d  = (state_d == ST_STOP || state_d == ST_SCROLL) ? pos_d : SEL_BLANK;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_STOP;
            pos_q   <= 3'd0;
            sel_q   <= 3'd0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            run_q   <= 2'b00;
            dir_q   <= 2'b00;
            blank_q <= 2'b00;
            step_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
            blank_q <= blank_d;
            step_q  <= step_d;
        end
    end

    assign SEL  = sel_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// tb/tb_hello_scroll_ctrl.sv - directed self-checking bench for hello_scroll_ctrl (TICK_DIV=4).
module tb_hello_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       blank = 1'b0;
    logic       step_n = 1'b1;
    logic [2:0] sel;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    hello_scroll_ctrl #(.TICK_DIV(4)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .RUN      (run),
        .DIR      (dir),
        .BLANK    (blank),
        .STEP_N   (step_n),
        .SEL      (sel),
        .TICK     (tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick_clk();
    endtask

    task automatic do_reset(input logic r, input logic d);
        @(negedge clk);
        rst_n  = 1'b0;
        run    = r;
        dir    = d;
        blank  = 1'b0;
        step_n = 1'b1;
        #2;
        check_eq("rst_sel", 32'(sel), 0);
        check_eq("rst_tick", 32'(tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int es, et, b;

        // forward scroll through a full cycle, checked every cycle
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 27; k++) begin
            tick_clk();
            if (k < 7) begin
                es = 0;
                et = 0;
            end else begin
                es = ((k - 7) / 4 + 1) % 5;
                et = ((k - 7) % 4 == 0) ? 1 : 0;
            end
`ifdef HELLO_WRAP_GAP_EN
            if (k >= 23 && k < 27) begin
                es = 5;
                et = 0;
            end else if (k == 27) begin
                es = 0;
                et = 1;
            end
`endif
            check_eq($sformatf("fwd_sel[%0d]", k), 32'(sel), 32'(es));
            check_eq($sformatf("fwd_tick[%0d]", k), 32'(tick), 32'(et));
        end

        // backward scroll, then DIR flipped mid-interval
        do_reset(1'b1, 1'b1);
        b = 7;
`ifdef HELLO_WRAP_GAP_EN
        run_to(7);
        check_eq("bwd_gap_sel", 32'(sel), 5);
        check_eq("bwd_gap_tick", 32'(tick), 0);
        b = 11;
`endif
        run_to(b);
        check_eq("bwd_sel4", 32'(sel), 4);
        check_eq("bwd_tick4", 32'(tick), 1);
        run_to(b + 1);
        check_eq("bwd_tick_off", 32'(tick), 0);
        run_to(b + 4);
        check_eq("bwd_sel3", 32'(sel), 3);
        run_to(b + 8);
        check_eq("bwd_sel2", 32'(sel), 2);
        check_eq("bwd_tick2", 32'(tick), 1);
        run_to(b + 9);
        dir = 1'b0;
        run_to(b + 11);
        check_eq("dir_hold_sel", 32'(sel), 2);
        run_to(b + 12);
        check_eq("dir_new_sel", 32'(sel), 3);
        check_eq("dir_new_tick", 32'(tick), 1);

        // manual step with a held button
        do_reset(1'b0, 1'b0);
        run_to(5);
        step_n = 1'b0;
        run_to(7);
        check_eq("man_sel_e2", 32'(sel), 0);
        check_eq("man_tick_e2", 32'(tick), 0);
        run_to(8);
        check_eq("man_sel_e3", 32'(sel), 1);
        check_eq("man_tick_e3", 32'(tick), 1);
        run_to(9);
        check_eq("man_tick_e4", 32'(tick), 0);
        run_to(15);
        check_eq("man_held_sel", 32'(sel), 1);
        step_n = 1'b1;
        run_to(20);
        check_eq("man_rel_sel", 32'(sel), 1);
        check_eq("man_rel_tick", 32'(tick), 0);
        step_n = 1'b0;
        run_to(23);
        check_eq("man2_sel", 32'(sel), 2);
        check_eq("man2_tick", 32'(tick), 1);

        // blank during scroll at pos 2, then resume
        do_reset(1'b1, 1'b0);
        run_to(11);
        check_eq("blk_pre_sel", 32'(sel), 2);
        blank = 1'b1;
        run_to(13);
        check_eq("blk_lat_sel", 32'(sel), 2);
        run_to(14);
        check_eq("blk_sel", 32'(sel), 5);
        check_eq("blk_tick", 32'(tick), 0);
        run_to(20);
        check_eq("blk_hold_sel", 32'(sel), 5);
        blank = 1'b0;
        run_to(22);
        check_eq("unblk_lat_sel", 32'(sel), 5);
        run_to(23);
        check_eq("unblk_sel", 32'(sel), 2);
        check_eq("unblk_tick", 32'(tick), 0);
        run_to(26);
        check_eq("unblk_hold_sel", 32'(sel), 2);
        run_to(27);
        check_eq("unblk_step_sel", 32'(sel), 3);
        check_eq("unblk_step_tick", 32'(tick), 1);

        // asynchronous reset mid-cycle at SEL=3
        do_reset(1'b1, 1'b0);
        run_to(15);
        check_eq("ar_pre_sel", 32'(sel), 3);
        check_eq("ar_pre_tick", 32'(tick), 1);
        run_to(16);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_sel", 32'(sel), 0);
        check_eq("ar_tick", 32'(tick), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hello_scroll_ctrl.md
HELLO_SCROLL_CTRL -- requirements
Module: hello_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, CLOCK_50 cycles per automatic scroll step; legal range 2 to 2^26-1.
REQ-002 SHALL have port CLOCK_50  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RUN  input  1  slide switch; 1 = automatic scroll.
REQ-005 SHALL have port DIR  input  1  slide switch; 0 = forward (pos +1), 1 = backward (pos -1).
REQ-006 SHALL have port BLANK  input  1  slide switch; 1 = force display blank; overrides RUN.
REQ-007 SHALL have port STEP_N  input  1  pushbutton, active-low, asynchronous; manual single step.
REQ-008 SHALL have port SEL  output  3  rotation select to the HELLO display decoder; 0-4 = rotation index, 5 (3'b101) = blank.
REQ-009 SHALL have port TICK  output  1  one-cycle pulse per position change, for a status LED.

Function
REQ-010 SHALL pass RUN, DIR, BLANK and STEP_N each through a two-flop synchronizer; all logic uses only synchronized copies.
REQ-011 SHALL hold a position register pos in the range 0-4; forward steps wrap 4->0, backward steps wrap 0->4; values 5-7 are never stored.
REQ-012 SHALL implement states STOP, SCROLL and BLANKED (plus GAP, see REQ-023), with next state from the synchronized levels: BLANK=1 -> BLANKED; else RUN=1 -> SCROLL; else STOP.
REQ-013 SHALL drive SEL from a register: SEL = pos in STOP and SCROLL, SEL = 5 in BLANKED and GAP.
REQ-014 SHALL run a prescaler in SCROLL only, counting 0 to TICK_DIV-1; at terminal count it clears and steps pos once in the direction given by synchronized DIR.
REQ-015 SHALL hold the prescaler at 0 in every state other than SCROLL, so the first step after entering SCROLL comes exactly TICK_DIV cycles after entry.
REQ-016 SHALL apply a DIR change to the next step only, without resetting the prescaler.
REQ-017 SHALL detect a falling edge of synchronized STEP_N: a 1->0 transition of the second sync flop, compared against a third history flop.
REQ-018 SHALL, in STOP only, step pos once per detected falling edge, updating SEL on the 3rd rising edge at which STEP_N is sampled low; a held button gives exactly one step; edges in SCROLL, BLANKED or GAP are discarded.
REQ-019 SHALL preserve pos across every state transition; leaving BLANKED restores SEL to the stored pos.
REQ-020 SHALL assert TICK for exactly one cycle, coincident with the first cycle the new pos appears on SEL; entering or leaving BLANKED or GAP gives no TICK.
REQ-021 SHALL, when a terminal count and a transition out of SCROLL occur in the same cycle, perform the step and then take the new state.

Reset
REQ-022 SHALL, while RST_N=0 and independent of CLOCK_50, force: state STOP, pos 0, SEL 0, TICK 0, prescaler 0, RUN/DIR/BLANK synchronizer flops 0, STEP_N synchronizer and history flops 1; after release, the first step occurs no earlier than the synchronizer latency.

Configuration
REQ-023 SHALL, with macro HELLO_WRAP_GAP_EN defined, replace every SCROLL wrap step (4->0 forward, 0->4 backward) with entry into GAP: SEL=5 for one full TICK_DIV interval, then pos takes the wrapped value with a TICK; BLANK=1 in GAP -> BLANKED with pos already wrapped; RUN=0 in GAP -> STOP with pos already wrapped.
REQ-024 SHALL, without HELLO_WRAP_GAP_EN, have no GAP state, so wraps are immediate; manual steps never use GAP in either build.

Verification (TICK_DIV=4)
REQ-025 SHALL cover: RUN=1 held through reset release -> SEL cycles 0,1,2,3,4,0, each value held 4 cycles, with one TICK at each change.
REQ-026 SHALL cover: RUN=1, DIR=1 from pos 0 -> SEL 4,3,2 at 4-cycle spacing; DIR toggled mid-interval -> next step follows the new direction, spacing unchanged.
REQ-027 SHALL cover: STOP with STEP_N low for 10 cycles -> SEL goes 0->1 on the 3rd edge with one TICK, and no further change until release and a new press.
REQ-028 SHALL cover: BLANK=1 while SCROLL at pos 2 -> SEL=5 with no TICK; BLANK=0 -> SEL=2 and the next step comes 4 cycles after SCROLL re-entry.
REQ-029 SHALL cover: HELLO_WRAP_GAP_EN defined, forward scroll at pos 4 -> SEL 4 (4 cycles), 5 (4 cycles), then 0 with TICK; undefined -> 4 then 0 directly.
REQ-030 SHALL cover: RST_N low mid-cycle while SEL=3 in SCROLL -> SEL=0 and TICK=0 before the next clock edge.
